// File: rtl/edge_fsm_pkg.sv
// Shared types and constants for the multi-channel debounced edge tracker.
package edge_fsm_pkg;

    // Per-channel tracker state; IDLE waits for the first sample after reset
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOW  = 3'd1,
        L2H  = 3'd2,
        HIGH = 3'd3,
        H2L  = 3'd4
    } edge_state_t;

    // Edge-select mode encodings; 2'b11 is reserved and treated as MODE_BOTH
    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

endpackage

// File: rtl/edge_fsm_chan.sv
// One channel of the debounced edge tracker: state machine, debounce counter,
// registered level and registered one-cycle edge strobe.
// hit is the combinational "accepted and mode-selected" strobe that edge_pulse
// will show on the next cycle; the top uses it to count events in step with edge_pulse.
module edge_fsm_chan
    import edge_fsm_pkg::*;
#(
    parameter int DB_CYC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic rise_en,
    input  logic fall_en,
    output logic edge_pulse,
    output logic level,
    output logic hit
);

    localparam int DBW = $clog2(DB_CYC + 1);

    edge_state_t     state, next_state;
    logic [DBW-1:0]  db_cnt, next_db;
    logic            rise_acc, fall_acc;

    // State, debounce count, level and strobe registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            db_cnt     <= '0;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            state      <= next_state;
            db_cnt     <= next_db;
            level      <= (next_state == HIGH) || (next_state == H2L);
            edge_pulse <= hit;
        end
    end

    // Next-state logic; completion is tested before increment so db_cnt never wraps
    always_comb begin
        next_state = state;
        next_db    = db_cnt;
        rise_acc   = 1'b0;
        fall_acc   = 1'b0;
        case (state)
            IDLE: begin
                next_db    = '0;
                next_state = in ? HIGH : LOW;
            end
            LOW: begin
                if (in) begin
                    if (DB_CYC == 1) begin
                        next_state = HIGH;
                        rise_acc   = 1'b1;
                    end else begin
                        next_state = L2H;
                        next_db    = DBW'(1);
                    end
                end
            end
            L2H: begin
                if (!in) begin
                    next_state = LOW;
                    next_db    = '0;
                end else if (int'(db_cnt) + 1 == DB_CYC) begin
                    next_state = HIGH;
                    next_db    = '0;
                    rise_acc   = 1'b1;
                end else begin
                    next_db = db_cnt + DBW'(1);
                end
            end
            HIGH: begin
                if (!in) begin
                    if (DB_CYC == 1) begin
                        next_state = LOW;
                        fall_acc   = 1'b1;
                    end else begin
                        next_state = H2L;
                        next_db    = DBW'(1);
                    end
                end
            end
            H2L: begin
                if (in) begin
                    next_state = HIGH;
                    next_db    = '0;
                end else if (int'(db_cnt) + 1 == DB_CYC) begin
                    next_state = LOW;
                    next_db    = '0;
                    fall_acc   = 1'b1;
                end else begin
                    next_db = db_cnt + DBW'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_db    = '0;
            end
        endcase
        hit = (rise_acc && rise_en) || (fall_acc && fall_en);
    end

endmodule

// File: rtl/edge_fsm_multi.sv
// Multi-channel debounced level/edge tracker.
// CH independent channels, each debounced over DB_CYC samples, with a
// runtime-selectable edge mode shared by all channels.
// Optional feature macro: EDGE_CNT_EN adds saturating per-channel event
// counters with synchronous clear; without it evt_cnt is tied to 0.
module edge_fsm_multi
    import edge_fsm_pkg::*;
#(
    parameter int CH     = 4,
    parameter int DB_CYC = 2,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH-1:0]       in,
    input  logic [1:0]          mode,
    input  logic                clr,
    output logic [CH-1:0]       edge_pulse,
    output logic [CH-1:0]       level,
    output logic [CH*CNT_W-1:0] evt_cnt
);

    logic          rise_en, fall_en;
    logic [CH-1:0] hit;

    // Reserved mode 2'b11 falls in with MODE_BOTH through the mode[1] term
    assign rise_en = (mode == MODE_RISE) || mode[1];
    assign fall_en = (mode == MODE_FALL) || mode[1];

    for (genvar k = 0; k < CH; k++) begin : g_chan
        edge_fsm_chan #(
            .DB_CYC (DB_CYC)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .in         (in[k]),
            .rise_en    (rise_en),
            .fall_en    (fall_en),
            .edge_pulse (edge_pulse[k]),
            .level      (level[k]),
            .hit        (hit[k])
        );

`ifdef EDGE_CNT_EN
        logic [CNT_W-1:0] cnt;

        // Saturating event counter, advancing on the edge that raises edge_pulse; clear wins
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (clr) begin
                cnt <= '0;
            end else if (hit[k] && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign evt_cnt[k*CNT_W +: CNT_W] = cnt;
`endif
    end

`ifndef EDGE_CNT_EN
    logic unused_cnt_inputs;

    assign evt_cnt           = '0;
    assign unused_cnt_inputs = clr ^ (^hit);
`endif

endmodule

// File: tb/tb_edge_fsm_multi.sv
// Self-checking bench for edge_fsm_multi (CH=4, DB_CYC=3, CNT_W=4).
// Expected values come from a run-length model: a channel accepts a new level
// once DB_CYC consecutive samples differ from its current accepted level.
module tb_edge_fsm_multi;

    localparam int CH     = 4;
    localparam int DB_CYC = 3;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [CH-1:0]       inReg = '0;
    logic [1:0]          modeReg = 2'b00;
    logic                clrReg = 1'b0;
    logic [CH-1:0]       edge_pulse;
    logic [CH-1:0]       level;
    logic [CH*CNT_W-1:0] evt_cnt;

    int totalChecks = 0;
    int badChecks   = 0;

    bit            mInit;
    logic [CH-1:0] mLevel;
    logic [CH-1:0] mPulse;
    int            mRun [CH];
    int            mCnt [CH];

    edge_fsm_multi #(
        .CH     (CH),
        .DB_CYC (DB_CYC),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (inReg),
        .mode       (modeReg),
        .clr        (clrReg),
        .edge_pulse (edge_pulse),
        .level      (level),
        .evt_cnt    (evt_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CH*CNT_W-1:0] expEvt();
        logic [CH*CNT_W-1:0] v;
        v = '0;
`ifdef EDGE_CNT_EN
        for (int k = 0; k < CH; k++) v[k*CNT_W +: CNT_W] = CNT_W'(mCnt[k]);
`endif
        return v;
    endfunction

    task automatic modelReset();
        mInit  = 1'b0;
        mLevel = '0;
        mPulse = '0;
        for (int k = 0; k < CH; k++) begin
            mRun[k] = 0;
            mCnt[k] = 0;
        end
    endtask

    task automatic modelUpdate();
        bit wantRise, wantFall;
        wantRise = (modeReg == 2'b00) || modeReg[1];
        wantFall = (modeReg == 2'b01) || modeReg[1];
        for (int k = 0; k < CH; k++) begin
            mPulse[k] = 1'b0;
            if (!mInit) begin
                mLevel[k] = inReg[k];
                mRun[k]   = 0;
            end else if (inReg[k] != mLevel[k]) begin
                mRun[k]++;
                if (mRun[k] == DB_CYC) begin
                    mPulse[k] = inReg[k] ? wantRise : wantFall;
                    mLevel[k] = inReg[k];
                    mRun[k]   = 0;
                end
            end else begin
                mRun[k] = 0;
            end
            if (clrReg) mCnt[k] = 0;
            else if (mPulse[k] && mCnt[k] < CMAX) mCnt[k]++;
        end
        mInit = 1'b1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".level"}, 32'(level), 32'(mLevel));
        checkOutput({tag, ".pulse"}, 32'(edge_pulse), 32'(mPulse));
        checkOutput({tag, ".evt"}, 32'(evt_cnt), 32'(expEvt()));
    endtask

    // One clock of stimulus: drive at negedge (also releasing reset), sample 1ns after posedge
    task automatic applyStimulus(input logic [CH-1:0] i, input logic [1:0] m, input logic c, input string tag);
        @(negedge clk);
        inReg   = i;
        modeReg = m;
        clrReg  = c;
        reset   = 1'b1;
        @(posedge clk);
        modelUpdate();
        #1;
        checkAll(tag);
    endtask

    initial begin
        logic [CH-1:0] cur;
        modelReset();

        // Asynchronous reset with a non-zero input pattern
        inReg = 4'b0101;
        #2 reset = 1'b0;
        #1;
        checkAll("rst");

        // First sample after release sets the baseline without a pulse
        applyStimulus(4'b0101, 2'b00, 1'b0, "base");
        checkOutput("base.level_const", 32'(level), 32'h5);

        // Fall on ch0 under rise mode, then a rise that must pulse after 3 samples
        for (int n = 0; n < 3; n++) applyStimulus(4'b0100, 2'b00, 1'b0, "ch0fall");
        for (int n = 0; n < 3; n++) applyStimulus(4'b0101, 2'b00, 1'b0, "ch0rise");
        checkOutput("ch0rise.pulse_const", 32'(edge_pulse), 32'h1);
        applyStimulus(4'b0101, 2'b00, 1'b0, "ch0hold");
        checkOutput("ch0hold.pulse_const", 32'(edge_pulse), 32'h0);

        // Two-sample glitch on ch1 is rejected
        for (int n = 0; n < 2; n++) applyStimulus(4'b0111, 2'b00, 1'b0, "glitch");
        for (int n = 0; n < 3; n++) applyStimulus(4'b0101, 2'b00, 1'b0, "glitch");

        // Fall-only, then both-edge mode with ch2 and ch3 moving together
        for (int n = 0; n < 3; n++) applyStimulus(4'b1111, 2'b01, 1'b0, "fallmode");
        for (int n = 0; n < 3; n++) applyStimulus(4'b0000, 2'b01, 1'b0, "fallmode");
        for (int n = 0; n < 3; n++) applyStimulus(4'b1100, 2'b10, 1'b0, "both");
        checkOutput("both.pair_const", 32'(edge_pulse), 32'hC);
        for (int n = 0; n < 3; n++) applyStimulus(4'b0000, 2'b11, 1'b0, "rsvd");

        // Counter saturation on ch0 and clear coinciding with a pulse
        applyStimulus(4'b0000, 2'b10, 1'b1, "clr");
        cur = 4'b0000;
        for (int e = 0; e < 17; e++) begin
            cur[0] = ~cur[0];
            for (int n = 0; n < 3; n++) applyStimulus(cur, 2'b10, 1'b0, "sat");
        end
`ifdef EDGE_CNT_EN
        checkOutput("sat.cnt_const", 32'(evt_cnt[CNT_W-1:0]), 32'd15);
`else
        checkOutput("nocnt.const", 32'(evt_cnt), 32'd0);
`endif
        cur[0] = ~cur[0];
        applyStimulus(cur, 2'b10, 1'b0, "clrpulse");
        applyStimulus(cur, 2'b10, 1'b0, "clrpulse");
        applyStimulus(cur, 2'b10, 1'b1, "clrpulse");
        checkOutput("clrpulse.pulse_const", 32'(edge_pulse[0]), 32'd1);
        checkOutput("clrpulse.cnt_const", 32'(evt_cnt[CNT_W-1:0]), 32'd0);

        // Reset mid-debounce clears outputs at once; restart with in high gives no pulse
        for (int n = 0; n < 3; n++) applyStimulus(4'b0100, 2'b00, 1'b0, "pre6");
        applyStimulus(4'b0001, 2'b00, 1'b0, "pre6");
        applyStimulus(4'b0101, 2'b00, 1'b0, "pre6");
        applyStimulus(4'b0101, 2'b00, 1'b0, "pre6");
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("midrst");
        applyStimulus(4'b0101, 2'b00, 1'b0, "postrst");
        checkOutput("postrst.level_const", 32'(level), 32'h5);

        // Randomized run against the model, including occasional clears and mode changes
        cur = inReg;
        for (int n = 0; n < 600; n++) begin
            logic [1:0] m;
            m = modeReg;
            for (int k = 0; k < CH; k++)
                if ($urandom_range(0, 5) == 0) cur[k] = ~cur[k];
            if ($urandom_range(0, 15) == 0) m = 2'($urandom_range(0, 3));
            applyStimulus(cur, m, ($urandom_range(0, 31) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
